// File: rtl/set_mode_ctrl.sv
// Front-panel controller: synchronises and debounces the MODE/SEL/INC
// buttons, runs the RUN/EDIT mode FSM and issues per-field increment
// strobes (with auto-repeat) to the time/date counters.

// One button: 2-FF synchroniser, stability-count debounce, press-edge detect.
module smc_btn #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_n;
    logic [CW-1:0] cnt;
    logic          level_q;

    // Count consecutive cycles the synced level disagrees with the accepted one;
    // any agreement restarts the count, so short glitches never get through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_n  <= 2'b11;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_n  <= {sync_n[0], raw_n};
            level_q <= level;
            if (!sync_n[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= !level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module set_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int TIMEOUT_SEC     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_sel_n,
    input  logic       btn_inc_n,
    input  logic       sec_tick,
    output logic       smh_dmy,
    output logic       dem_chinh,
    output logic [1:0] blink_led,
    output logic [5:0] inc_pulse
);
    localparam int NB   = 3;
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic {RUN, EDIT} state_t;

    logic [NB-1:0] raw_n;
    logic [NB-1:0] deb;
    logic [NB-1:0] ev;
    logic          unused_deb;

    state_t        state;
    logic [TW-1:0] tmo;
    logic          rpt_on;
    logic          rpt_hold;
    logic [RW-1:0] rpt_cnt;

    logic ev_mode, ev_sel, ev_inc, any_ev, tmo_hit, rpt_hit;

    assign raw_n      = {btn_inc_n, btn_sel_n, btn_mode_n};
    assign unused_deb = &{1'b0, deb[1:0]};

    for (genvar b = 0; b < NB; b++) begin : g_btn
        smc_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_n (raw_n[b]),
            .level (deb[b]),
            .press (ev[b])
        );
    end

    // MODE beats SEL beats INC; losers in the same cycle are dropped.
    assign ev_mode = ev[0];
    assign ev_sel  = ev[1] & ~ev[0];
    assign ev_inc  = ev[2] & ~ev[1] & ~ev[0];
    assign any_ev  = |ev;
    assign tmo_hit = tmo >= TW'(TIMEOUT_SEC - 1);
    assign rpt_hit = rpt_hold ? (rpt_cnt == RW'(HOLD_CYCLES)) : (rpt_cnt == RW'(REPEAT_CYCLES));

    // Selected field -> one-hot counter strobe.
    function automatic logic [5:0] field_strobe(input logic dmy, input logic [1:0] fld);
        case ({dmy, fld})
            3'b0_01: field_strobe = 6'b000100;
            3'b0_10: field_strobe = 6'b000010;
            3'b0_11: field_strobe = 6'b000001;
            3'b1_01: field_strobe = 6'b001000;
            3'b1_10: field_strobe = 6'b010000;
            3'b1_11: field_strobe = 6'b100000;
            default: field_strobe = 6'b000000;
        endcase
    endfunction

    // Mode FSM with registered outputs, edit timeout and inc auto-repeat.
    // The repeat counter keeps its cadence even when a strobe is suppressed by
    // a same-cycle event or timeout, so the repeat phase never drifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            smh_dmy   <= 1'b0;
            dem_chinh <= 1'b0;
            blink_led <= 2'b00;
            inc_pulse <= 6'b0;
            tmo       <= '0;
            rpt_on    <= 1'b0;
            rpt_hold  <= 1'b0;
            rpt_cnt   <= '0;
        end else begin
            inc_pulse <= 6'b0;
            if (rpt_on) begin
                if (rpt_hit) begin
                    rpt_cnt  <= RW'(1);
                    rpt_hold <= 1'b0;
                end else begin
                    rpt_cnt <= rpt_cnt + RW'(1);
                end
            end
            if (!deb[2]) rpt_on <= 1'b0;

            case (state)
                RUN: begin
                    if (ev_mode) begin
                        smh_dmy <= !smh_dmy;
                    end else if (ev_sel) begin
                        state     <= EDIT;
                        dem_chinh <= 1'b1;
                        blink_led <= 2'b01;
                        tmo       <= '0;
                    end
                end
                EDIT: begin
                    if (any_ev) tmo <= '0;
                    if (ev_mode) begin
                        smh_dmy   <= !smh_dmy;
                        blink_led <= 2'b01;
                    end else if (ev_sel) begin
                        if (blink_led == 2'b11) begin
                            state     <= RUN;
                            dem_chinh <= 1'b0;
                            blink_led <= 2'b00;
                            rpt_on    <= 1'b0;
                        end else begin
                            blink_led <= blink_led + 2'b01;
                        end
                    end else if (ev_inc) begin
                        inc_pulse <= field_strobe(smh_dmy, blink_led);
                        rpt_on    <= 1'b1;
                        rpt_hold  <= 1'b1;
                        rpt_cnt   <= RW'(1);
                    end else if (sec_tick && tmo_hit) begin
                        state     <= RUN;
                        dem_chinh <= 1'b0;
                        blink_led <= 2'b00;
                        rpt_on    <= 1'b0;
                        tmo       <= '0;
                    end else begin
                        if (sec_tick) tmo <= tmo + TW'(1);
                        if (rpt_on && deb[2] && rpt_hit)
                            inc_pulse <= field_strobe(smh_dmy, blink_led);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: directed scenarios plus random button/tick
// traffic, every cycle compared against a behavioural model of the panel.
module tb_set_mode_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int TMO  = 3;

    logic       clk = 1'b0;
    logic       rst_n, btn_mode_n, btn_sel_n, btn_inc_n, sec_tick;
    logic       smh_dmy, dem_chinh;
    logic [1:0] blink_led;
    logic [5:0] inc_pulse;

    int nchk = 0;
    int nerr = 0;

    set_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_SEC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode_n(btn_mode_n), .btn_sel_n(btn_sel_n),
        .btn_inc_n(btn_inc_n), .sec_tick(sec_tick), .smh_dmy(smh_dmy),
        .dem_chinh(dem_chinh), .blink_led(blink_led), .inc_pulse(inc_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons: accepted level flips once the synced level (raw delayed two
    // samples) has disagreed for DB consecutive samples; a press is seen by
    // the FSM one cycle after acceptance. Auto-repeat is pure time arithmetic
    // from the initial press.
    int       cyc;
    bit       m_edit, m_smh, m_rpt;
    bit [1:0] m_led;
    bit [5:0] m_inc;
    bit       m_deb[3];
    bit       m_ev[3];
    bit       hist[3][DB+1];
    int       m_tmo, m_e0;

    function automatic bit [5:0] fmap(input bit dmy, input bit [1:0] f);
        bit [5:0] hms[4] = '{6'b0, 6'b000100, 6'b000010, 6'b000001};
        bit [5:0] dmyv[4] = '{6'b0, 6'b001000, 6'b010000, 6'b100000};
        return dmy ? dmyv[f] : hms[f];
    endfunction

    task automatic m_reset();
        m_edit = 0; m_smh = 0; m_led = 0; m_inc = 0; m_rpt = 0; m_tmo = 0; m_e0 = 0;
        for (int b = 0; b < 3; b++) begin
            m_deb[b] = 0; m_ev[b] = 0;
            for (int k = 0; k <= DB; k++) hist[b][k] = 0;
        end
    endtask

    task automatic m_step();
        int win;
        bit hit, texit, flip;
        bit raw[3];
        raw[0] = !btn_mode_n; raw[1] = !btn_sel_n; raw[2] = !btn_inc_n;
        cyc++;
        m_inc = 0;
        texit = 0;
        win = m_ev[0] ? 1 : m_ev[1] ? 2 : m_ev[2] ? 3 : 0;
        if (!m_deb[2]) m_rpt = 0;
        if (!m_edit) begin
            if (win == 1) m_smh = !m_smh;
            else if (win == 2) begin m_edit = 1; m_led = 1; m_tmo = 0; end
        end else if (win != 0) begin
            m_tmo = 0;
            if (win == 1) begin m_smh = !m_smh; m_led = 1; end
            else if (win == 2) begin
                if (m_led == 3) begin m_edit = 0; m_led = 0; m_rpt = 0; end
                else m_led = m_led + 1;
            end else begin
                m_inc = fmap(m_smh, m_led); m_rpt = 1; m_e0 = cyc;
            end
        end else begin
            hit = m_rpt && (cyc - m_e0) >= HOLD && ((cyc - m_e0 - HOLD) % REP) == 0;
            if (sec_tick) begin
                m_tmo++;
                if (m_tmo >= TMO) begin m_edit = 0; m_led = 0; m_rpt = 0; texit = 1; end
            end
            if (hit && !texit) m_inc = fmap(m_smh, m_led);
        end
        for (int b = 0; b < 3; b++) begin
            flip = 1;
            for (int k = 1; k <= DB; k++) if (hist[b][k] == m_deb[b]) flip = 0;
            m_ev[b] = flip && !m_deb[b];
            if (flip) m_deb[b] = !m_deb[b];
            for (int k = DB; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
        end
    endtask

    // Per-cycle comparison against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        if (!rst_n) m_reset(); else m_step();
        #1;
        chk("smh", smh_dmy, m_smh);
        chk("dem", dem_chinh, m_edit);
        chk("led", blink_led, m_led);
        chk("inc", inc_pulse, m_inc);
    end

    // ---------------- stimulus ----------------
    bit tick_en = 0;
    bit tick_now = 0;
    int scnt = 0;
    int pt[$];
    bit [5:0] pv[$];

    task automatic step();
        @(negedge clk);
        scnt++;
        sec_tick = tick_now || (tick_en && ($urandom_range(0, 11) == 0));
        tick_now = 0;
        if (inc_pulse != 6'b0) begin pt.push_back(scnt); pv.push_back(inc_pulse); end
    endtask

    task automatic set_btn(input bit [2:0] m, input logic v);
        if (m[0]) btn_mode_n = v;
        if (m[1]) btn_sel_n  = v;
        if (m[2]) btn_inc_n  = v;
    endtask

    task automatic press(input bit [2:0] m, input int hold, input int gap);
        set_btn(m, 1'b0);
        repeat (hold) step();
        set_btn(m, 1'b1);
        repeat (gap) step();
    endtask

    task automatic tick();
        tick_now = 1; step(); step();
    endtask

    bit seen;
    bit [5:0] acc;

    initial begin
        rst_n = 0; btn_mode_n = 1; btn_sel_n = 1; btn_inc_n = 1; sec_tick = 0;
        repeat (3) step();
        rst_n = 1;
        chk("rst_smh", smh_dmy, 0);
        chk("rst_dem", dem_chinh, 0);
        chk("rst_led", blink_led, 0);
        chk("rst_inc", inc_pulse, 0);

        // glitch shorter than the debounce window
        press(3'b010, 3, 10);
        chk("glitch_dem", dem_chinh, 0);
        chk("glitch_led", blink_led, 0);

        // clean SEL press enters EDIT within 7 edges
        btn_sel_n = 0;
        seen = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (dem_chinh) seen = 1;
        end
        chk("sel_latency", seen, 1);
        repeat (3) step();
        btn_sel_n = 1;
        repeat (10) step();
        chk("walk1_led", blink_led, 2'b01);
        press(3'b010, 8, 8);
        chk("walk2_led", blink_led, 2'b10);
        chk("walk2_dem", dem_chinh, 1);
        press(3'b010, 8, 8);
        chk("walk3_led", blink_led, 2'b11);
        chk("walk3_dem", dem_chinh, 1);
        press(3'b010, 8, 8);
        chk("walk4_led", blink_led, 2'b00);
        chk("walk4_dem", dem_chinh, 0);

        // field mapping: date view month, then time view minutes
        press(3'b010, 8, 8);
        press(3'b001, 8, 8);
        press(3'b010, 8, 8);
        pt.delete(); pv.delete();
        press(3'b100, 8, 8);
        chk("map_mo_n", pt.size(), 1);
        chk("map_mo", (pv.size() > 0) ? pv[0] : 6'b0, 6'b010000);
        press(3'b001, 8, 8);
        press(3'b010, 8, 8);
        pt.delete(); pv.delete();
        press(3'b100, 8, 8);
        chk("map_mm_n", pt.size(), 1);
        chk("map_mm", (pv.size() > 0) ? pv[0] : 6'b0, 6'b000010);

        // auto-repeat on hours: press at t, then t+20, then every 5 until release
        press(3'b001, 8, 8);
        press(3'b001, 8, 8);
        pt.delete(); pv.delete();
        press(3'b100, 60, 15);
        chk("rpt_n", pt.size(), 9);
        if (pt.size() >= 3) begin
            chk("rpt_gap1", pt[1] - pt[0], HOLD);
            chk("rpt_gap2", pt[2] - pt[1], REP);
        end
        acc = 0;
        foreach (pv[i]) acc |= pv[i];
        chk("rpt_field", acc, 6'b000100);

        // timeout after three idle seconds
        tick(); step(); tick(); step();
        chk("tmo_pre", dem_chinh, 1);
        tick();
        chk("tmo_dem", dem_chinh, 0);
        chk("tmo_led", blink_led, 0);

        // press coinciding with the third tick keeps EDIT
        press(3'b010, 8, 8);
        tick(); step(); tick(); step();
        btn_mode_n = 0;
        repeat (5) step();
        tick_now = 1; step(); step();
        step();
        btn_mode_n = 1;
        repeat (8) step();
        chk("tmo_race_dem", dem_chinh, 1);
        chk("tmo_race_smh", smh_dmy, 1);
        tick(); tick(); tick();
        chk("tmo2_dem", dem_chinh, 0);

        // MODE and SEL together in RUN: MODE wins
        press(3'b011, 8, 8);
        chk("prio_smh", smh_dmy, 0);
        chk("prio_dem", dem_chinh, 0);

        // random traffic
        tick_en = 1;
        for (int i = 0; i < 80; i++) begin
            int r, len;
            bit [2:0] m;
            r = $urandom_range(0, 9);
            if (r < 3) m = 3'b001;
            else if (r < 7) m = 3'b010;
            else if (r < 9) m = 3'b100;
            else m = 3'($urandom_range(1, 7));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
            press(m, len, $urandom_range(1, 12));
        end
        tick_en = 0;
        repeat (10) step();

        // asynchronous reset mid-edit with INC held
        rst_n = 0; step(); step(); rst_n = 1;
        press(3'b010, 8, 8);
        chk("ar_pre_dem", dem_chinh, 1);
        btn_inc_n = 0;
        repeat (30) step();
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("ar_smh", smh_dmy, 0);
        chk("ar_dem", dem_chinh, 0);
        chk("ar_led", blink_led, 0);
        chk("ar_inc", inc_pulse, 0);
        repeat (3) step();
        btn_inc_n = 1;
        rst_n = 1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
